// File: rtl/wb_reram_multi_slave.sv
// Wishbone classic slave that decodes a word-per-channel window and forwards each
// access to one of N_CH ReRAM cores, terminating with ack, or err on decode failure or timeout.
module wb_reram_multi_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] WIN_MASK  = 32'h0000_00FF,
    parameter int          N_CH      = 4,
    parameter logic [3:0]  REQ_SEL   = 4'b1111,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [3:0]           wbs_sel_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic [N_CH-1:0]      core_en_o,
    output logic                 core_r_wb_o,
    output logic [31:0]          core_wdata_o,
    input  logic [N_CH*32-1:0]   core_rdata_i,
    input  logic [N_CH-1:0]      core_ack_i
);

    localparam int          IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_ERR} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             r_wb;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [15:0]      cnt;

    logic [31:0]      word_off;
    logic             req_good;
    logic             sel_ack;
    logic [31:0]      sel_rdata;
    logic [15:0]      cnt_nxt;

    // The wait counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        word_off = (wbs_adr_i & WIN_MASK) >> 2;
        req_good = ((wbs_adr_i & ~WIN_MASK) == BASE_ADDR)
                && (wbs_adr_i[1:0] == 2'b00)
                && (word_off < 32'(N_CH))
                && (wbs_sel_i == REQ_SEL);
        cnt_nxt  = sat_inc(cnt);
    end

    // Only the captured channel's ack and data are observed; other channels are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_ack   = core_ack_i[k];
                sel_rdata = core_rdata_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            idx   <= '0;
            r_wb  <= 1'b0;
            wdata <= '0;
            rdata <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        if (req_good) begin
                            idx   <= wbs_adr_i[2 +: IDX_W];
                            r_wb  <= ~wbs_we_i;
                            wdata <= wbs_dat_i;
                            state <= S_ISSUE;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= wbs_cyc_i ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    // A master abort wins over a same-cycle core ack.
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (sel_ack) begin
                        if (r_wb) rdata <= sel_rdata;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt_nxt;
                        if (TIMEOUT != 0 && cnt_nxt == TO_CNT) state <= S_ERR;
                    end
                end
                S_ACK:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            core_en_o[k] = (state == S_ISSUE) && (idx == IDX_W'(k));
        end
    end

    assign wbs_ack_o    = (state == S_ACK);
    assign wbs_err_o    = (state == S_ERR);
    assign wbs_dat_o    = rdata;
    assign core_r_wb_o  = r_wb;
    assign core_wdata_o = wdata;

endmodule

// File: tb/tb_wb_reram_multi_slave.sv
// Randomised transaction-level bench for wb_reram_multi_slave; a second instance
// with the timeout disabled covers the no-timeout configuration.
module tb_wb_reram_multi_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] WIN  = 32'h0000_00FF;
    localparam int          N_CH = 4;
    localparam int          TO   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we_i;
    logic [31:0]  adr_i, dat_i;
    logic [3:0]   sel_i;
    logic [31:0]  rd [N_CH];
    logic [127:0] core_rdata;
    logic [3:0]   core_ack;

    logic [31:0]  wb_dat, wdata;
    logic         wb_ack, wb_err, rwb;
    logic [3:0]   core_en;

    logic [31:0]  wb_dat0, wdata0;
    logic         wb_ack0, wb_err0, rwb0;
    logic [3:0]   core_en0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_dat, m_wdata;
    logic        m_rwb;

    assign core_rdata = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    wb_reram_multi_slave #(.BASE_ADDR(BASE), .WIN_MASK(WIN), .N_CH(N_CH),
                           .REQ_SEL(4'b1111), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_sel_i(sel_i),
        .wbs_dat_o(wb_dat), .wbs_ack_o(wb_ack), .wbs_err_o(wb_err),
        .core_en_o(core_en), .core_r_wb_o(rwb), .core_wdata_o(wdata),
        .core_rdata_i(core_rdata), .core_ack_i(core_ack));

    wb_reram_multi_slave #(.BASE_ADDR(BASE), .WIN_MASK(WIN), .N_CH(N_CH),
                           .REQ_SEL(4'b1111), .TIMEOUT(0)) dut_nto (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_sel_i(sel_i),
        .wbs_dat_o(wb_dat0), .wbs_ack_o(wb_ack0), .wbs_err_o(wb_err0),
        .core_en_o(core_en0), .core_r_wb_o(rwb0), .core_wdata_o(wdata0),
        .core_rdata_i(core_rdata), .core_ack_i(core_ack));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete Wishbone access. d = WAIT cycle in which the selected core acks
    // (0 = during ISSUE, negative = never). Expected outcome comes from the decode/timeout rules.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int d, input bit b2b);
        logic [31:0] off;
        bit          good, exp_ack, got_ack, both;
        int          idx, term, seen, en_cnt;
        logic [3:0]  en_val, av;
        off  = (adr & WIN) >> 2;
        good = ((adr & ~WIN) == BASE) && (adr[1:0] == 2'b00) && (off < N_CH) && (sel == 4'hF);
        idx  = int'(off[1:0]);
        if (!good) begin
            term = 0; exp_ack = 0;
        end else if (d >= 1 && d <= TO) begin
            term = d + 1; exp_ack = 1;
        end else begin
            term = TO + 1; exp_ack = 0;
        end
        if (good) begin
            m_rwb   = ~we;
            m_wdata = dat;
            if (exp_ack && !we) m_dat = rd[idx];
        end
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        seen = -1; got_ack = 0; both = 0; en_cnt = 0; en_val = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (core_en != 4'd0) begin
                en_cnt++;
                en_val = core_en;
            end
            if (wb_ack || wb_err) begin
                seen = k; got_ack = wb_ack; both = wb_ack && wb_err;
                break;
            end
            av = 4'($urandom);
            if (good) av[idx] = (k == d);
            core_ack = av;
        end
        core_ack = '0;
        check("term_cycle", 32'(seen), 32'(term));
        check("term_is_ack", 32'(got_ack), 32'(exp_ack));
        check("ack_err_excl", 32'(both), 32'd0);
        check("en_pulses", 32'(en_cnt), good ? 32'd1 : 32'd0);
        if (good) check("en_onehot", 32'(en_val), 32'd1 << idx);
        check("dat_o", wb_dat, m_dat);
        check("r_wb", 32'(rwb), 32'(m_rwb));
        check("wdata", wdata, m_wdata);
        if (!b2b) begin
            cyc = 1'b0; stb = 1'b0;
        end
        @(posedge clk); #1;
        check("idle_after", {26'd0, wb_ack, wb_err, core_en}, 32'd0);
    endtask

    initial begin
        int n_bad, n_err_main, n_ack_err, n_en, sel_pick;
        logic [31:0] a;
        logic [3:0]  s;

        rst = 1'b1; cyc = 0; stb = 0; we_i = 0; adr_i = 0; dat_i = 0; sel_i = 0; core_ack = 0;
        for (int i = 0; i < N_CH; i++) rd[i] = 32'h1111_0000 + 32'(i);
        m_dat = 0; m_wdata = 0; m_rwb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {25'd0, wb_ack, wb_err, core_en, rwb}, 32'd0);
        check("rst_dat", wb_dat, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read, write and decode failures
        rd[2] = 32'hA5A5_0002;
        run_txn(BASE + 32'd8, 1'b0, 32'h0, 4'hF, 1, 0);
        run_txn(BASE, 1'b1, 32'hDEAD_BEEF, 4'hF, 5, 0);
        run_txn(BASE + 32'd16, 1'b0, 32'h0, 4'hF, 1, 0);
        run_txn(BASE + 32'd2, 1'b0, 32'h0, 4'hF, 1, 0);
        run_txn(BASE + 32'd4, 1'b1, 32'h1234_5678, 4'b0010, 1, 0);
        run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1, 0);

        // Timeout on the default instance
        run_txn(BASE + 32'd4, 1'b0, 32'h0, 4'hF, -1, 0);

        // Timeout disabled: the second instance must keep waiting
        cyc = 1; stb = 1; we_i = 0; adr_i = BASE + 32'd4; dat_i = 32'h0; sel_i = 4'hF;
        m_rwb = 1'b1; m_wdata = 32'h0;
        n_bad = 0; n_err_main = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            stb = 1'b0;
            if (wb_ack0 || wb_err0) n_bad++;
            if (wb_err) n_err_main++;
        end
        check("nto_no_term", 32'(n_bad), 32'd0);
        check("to_main_err_once", 32'(n_err_main), 32'd1);
        cyc = 1'b0;
        @(posedge clk); #1;
        check("nto_abort_idle", {26'd0, wb_ack0, wb_err0, core_en0}, 32'd0);
        check("nto_dat", wb_dat0, m_dat);
        check("nto_rwb", 32'(rwb0), 32'(m_rwb));

        // Timeout boundaries and ack during ISSUE
        rd[1] = 32'h0BAD_CAFE;
        run_txn(BASE + 32'd4, 1'b0, 32'h0, 4'hF, 16, 0);
        run_txn(BASE + 32'd4, 1'b0, 32'h0, 4'hF, 17, 0);
        run_txn(BASE + 32'd12, 1'b0, 32'h0, 4'hF, 0, 0);

        // Abort in WAIT, then a late ack from the core
        cyc = 1; stb = 1; we_i = 0; adr_i = BASE + 32'd4; sel_i = 4'hF;
        m_rwb = 1'b1; m_wdata = dat_i;
        n_ack_err = 0; n_en = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (wb_ack || wb_err) n_ack_err++;
            if (core_en != 4'd0) n_en++;
            if (k == 2) begin
                cyc = 0; stb = 0;
            end
            core_ack = (k == 4) ? 4'b0010 : 4'b0000;
        end
        core_ack = '0;
        check("abort_no_term", 32'(n_ack_err), 32'd0);
        check("abort_en_once", 32'(n_en), 32'd1);
        check("abort_dat", wb_dat, m_dat);
        rd[3] = 32'h3333_CCCC;
        run_txn(BASE + 32'd12, 1'b0, 32'h0, 4'hF, 1, 0);

        // Asynchronous reset in WAIT
        cyc = 1; stb = 1; we_i = 1; adr_i = BASE + 32'd8; dat_i = 32'hFEED_0001; sel_i = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("arst_ctl", {25'd0, wb_ack, wb_err, core_en, rwb}, 32'd0);
        check("arst_dat", wb_dat, 32'd0);
        check("arst_wdata", wdata, 32'd0);
        core_ack = 4'b0100; cyc = 0; stb = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ack_ignored", {26'd0, wb_ack, wb_err, core_en}, 32'd0);
        core_ack = '0;
        m_dat = 0; m_wdata = 0; m_rwb = 0;

        // Back-to-back reads across all channels
        for (int i = 0; i < N_CH; i++) rd[i] = $urandom;
        for (int i = 0; i < N_CH; i++)
            run_txn(BASE + 32'(4 * i), 1'b0, 32'h0, 4'hF, 1, i != N_CH - 1);

        // Randomised mix of good, malformed and slow accesses
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N_CH; i++) rd[i] = $urandom;
            sel_pick = $urandom_range(0, 9);
            s = 4'hF;
            if (sel_pick <= 5)      a = BASE + 32'(4 * $urandom_range(0, N_CH - 1));
            else if (sel_pick == 6) a = BASE + 32'(4 * $urandom_range(N_CH, 63));
            else if (sel_pick == 7) a = BASE + 32'(4 * $urandom_range(0, N_CH - 1)) + 32'($urandom_range(1, 3));
            else if (sel_pick == 8) begin
                a = $urandom;
                if ((a & ~WIN) == BASE) a = a ^ 32'h8000_0000;
            end else begin
                a = BASE + 32'(4 * $urandom_range(0, N_CH - 1));
                s = 4'($urandom_range(0, 14));
            end
            run_txn(a, 1'($urandom), $urandom, s, $urandom_range(0, 19), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
